// File: rtl/fc_pkg.sv
// Shared constants, state encoding and the output saturation helper for the
// two-layer fully-connected engine.
package fc_pkg;

    localparam int IN_LEN    = 132;
    localparam int N_HID     = 10;
    localparam int DW        = 8;
    localparam int OUT_W     = 24;
    localparam int FC1_WORDS = IN_LEN * N_HID;
    localparam int ACC1_W    = 24;
    localparam int ACC2_W    = 36;
    localparam int IN_AW     = 8;
    localparam int W1_AW     = 11;
    localparam int HID_AW    = 4;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_FC1  = 3'd1;
    localparam state_t ST_FC2  = 3'd2;
    localparam state_t ST_FIN  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam logic signed [ACC2_W-1:0] OUT_MAX =
        {{(ACC2_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC2_W-1:0] OUT_MIN =
        {{(ACC2_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Clamp a wide accumulator value into the signed OUT_W range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC2_W-1:0] v);
        if (v > OUT_MAX)
            return {1'b0, {(OUT_W-1){1'b1}}};
        else if (v < OUT_MIN)
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/fc_mac.sv
// Signed multiply-accumulate with synchronous clear and enable; sum_o exposes
// the value the accumulator would take this cycle so callers can capture it.
module fc_mac
    import fc_pkg::*;
#(
    parameter int A_W   = OUT_W,
    parameter int B_W   = DW,
    parameter int ACC_W = ACC2_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] acc_o,
    output logic signed [ACC_W-1:0] sum_o
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   a_ext, b_ext, prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q;

    assign a_ext    = {{B_W{a_i[A_W-1]}}, a_i};
    assign b_ext    = {{A_W{b_i[B_W-1]}}, b_i};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    assign sum_o    = acc_q + prod_ext;
    assign acc_o    = acc_q;

    // Clear wins over enable so a neuron's final sum can be captured from
    // sum_o while the accumulator restarts for the next neuron.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else if (clr_i)
            acc_q <= '0;
        else if (en_i)
            acc_q <= sum_o;
    end

endmodule

// File: rtl/fc_top.sv
// Two-layer fully-connected inference engine: FC1 (132x10, ReLU) then FC2
// (10x1, saturated), computed sequentially on one shared MAC.
module fc_top
    import fc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_wr,
    input  logic [7:0]        in_addr,
    input  logic [DW-1:0]     in_data,
    input  logic              fc1_w_wr,
    input  logic [15:0]       fc1_w_addr,
    input  logic [DW-1:0]     fc1_w_data,
    input  logic              fc2_w_wr,
    input  logic [3:0]        fc2_w_addr,
    input  logic [DW-1:0]     fc2_w_data,
    input  logic              start,
    output logic              done,
    output logic [OUT_W-1:0]  fc2_logit
);

    logic signed [DW-1:0]    in_buf [IN_LEN];
    logic signed [DW-1:0]    w1_buf [FC1_WORDS];
    logic signed [DW-1:0]    w2_buf [N_HID];
    logic signed [OUT_W-1:0] fc1_out_relu [N_HID];

    state_t                  state_q, state_d;
    logic [HID_AW-1:0]       n_q, n_d;
    logic [IN_AW-1:0]        j_q, j_d;
    logic [W1_AW-1:0]        widx_q, widx_d;
    logic                    done_q, done_d;
    logic signed [OUT_W-1:0] logit_q, logit_d;

    logic                    mac_clr, mac_en, relu_we;
    logic signed [OUT_W-1:0] mac_a, relu_val;
    logic signed [DW-1:0]    mac_b, in_cur;
    logic signed [ACC2_W-1:0] mac_acc, mac_sum;
    logic                    wr_ok;

    assign wr_ok = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Buffers are deliberately not reset so weights survive a reset.
    always_ff @(posedge clk) begin
        if (in_wr && wr_ok && (in_addr < IN_AW'(IN_LEN)))
            in_buf[in_addr] <= in_data;
        if (fc1_w_wr && wr_ok && (fc1_w_addr < 16'(FC1_WORDS)))
            w1_buf[fc1_w_addr[W1_AW-1:0]] <= fc1_w_data;
        if (fc2_w_wr && wr_ok && (fc2_w_addr < HID_AW'(N_HID)))
            w2_buf[fc2_w_addr] <= fc2_w_data;
    end

    assign in_cur = in_buf[j_q];

    always_comb begin
        mac_a = '0;
        mac_b = '0;
        if (state_q == ST_FC1) begin
            mac_a = {{(OUT_W-DW){in_cur[DW-1]}}, in_cur};
            mac_b = w1_buf[widx_q];
        end else if (state_q == ST_FC2) begin
            mac_a = fc1_out_relu[n_q];
            mac_b = w2_buf[n_q];
        end
    end

    // One wide accumulator serves both layers; an FC1 dot product is bounded
    // by 132*128*128, so it is exact in ACC1_W bits and never saturates.
    fc_mac #(.A_W(OUT_W), .B_W(DW), .ACC_W(ACC2_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (mac_a),
        .b_i   (mac_b),
        .acc_o (mac_acc),
        .sum_o (mac_sum)
    );

    assign relu_val = mac_sum[ACC2_W-1] ? '0 : sat_out(mac_sum);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        j_d     = j_q;
        widx_d  = widx_q;
        done_d  = done_q;
        logit_d = logit_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        relu_we = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FC1;
                    done_d  = 1'b0;
                    mac_clr = 1'b1;
                    n_d     = '0;
                    j_d     = '0;
                    widx_d  = '0;
                end
            end
            ST_FC1: begin
                mac_en = 1'b1;
                widx_d = widx_q + 1'b1;
                if (j_q == IN_AW'(IN_LEN-1)) begin
                    relu_we = 1'b1;
                    mac_clr = 1'b1;
                    j_d     = '0;
                    if (n_q == HID_AW'(N_HID-1)) begin
                        n_d     = '0;
                        widx_d  = '0;
                        state_d = ST_FC2;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_FC2: begin
                mac_en = 1'b1;
                if (n_q == HID_AW'(N_HID-1))
                    state_d = ST_FIN;
                else
                    n_d = n_q + 1'b1;
            end
            ST_FIN: begin
                logit_d = sat_out(mac_acc);
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            j_q     <= '0;
            widx_q  <= '0;
            done_q  <= 1'b0;
            logit_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            j_q     <= j_d;
            widx_q  <= widx_d;
            done_q  <= done_d;
            logit_q <= logit_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_HID; i++)
                fc1_out_relu[i] <= '0;
        end else if (relu_we) begin
            fc1_out_relu[n_q] <= relu_val;
        end
    end

    assign done      = done_q;
    assign fc2_logit = logit_q;

endmodule

// File: tb/tb_fc_top.sv
// Directed bench for fc_top: table of full inference runs plus hand-written
// rerun, guard and mid-run reset sequences.
module tb_fc_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_wr, fc1_w_wr, fc2_w_wr, start;
    logic [7:0]  in_addr, in_data, fc1_w_data, fc2_w_data;
    logic [15:0] fc1_w_addr;
    logic [3:0]  fc2_w_addr;
    logic        done;
    logic [23:0] fc2_logit;

    int checks = 0;
    int errors = 0;

    fc_top dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_wr      (in_wr),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .fc1_w_wr   (fc1_w_wr),
        .fc1_w_addr (fc1_w_addr),
        .fc1_w_data (fc1_w_data),
        .fc2_w_wr   (fc2_w_wr),
        .fc2_w_addr (fc2_w_addr),
        .fc2_w_data (fc2_w_data),
        .start      (start),
        .done       (done),
        .fc2_logit  (fc2_logit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int in_mode;   // 0: (i%8)-3, 1: all 127
        int w1_mode;   // 0: n+1, 1: -(n+1), 2: all 127
        int w2_val;
        int relu_mul;  // expected relu[n] = relu_mul*(n+1) + relu_add
        int relu_add;
        int exp_logit;
    } vec_t;

    vec_t vecs [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic load_in(input int mode);
        for (int i = 0; i < 132; i++) begin
            in_wr   = 1'b1;
            in_addr = 8'(i);
            in_data = (mode == 0) ? 8'((i % 8) - 3) : 8'd127;
            tick();
        end
        in_wr = 1'b0;
    endtask

    task automatic load_w1(input int mode);
        for (int n = 0; n < 10; n++) begin
            for (int j = 0; j < 132; j++) begin
                fc1_w_wr   = 1'b1;
                fc1_w_addr = 16'(n * 132 + j);
                fc1_w_data = (mode == 0) ? 8'(n + 1) : (mode == 1) ? 8'(-(n + 1)) : 8'd127;
                tick();
            end
        end
        fc1_w_wr = 1'b0;
    endtask

    task automatic load_w2(input int v);
        for (int k = 0; k < 10; k++) begin
            fc2_w_wr   = 1'b1;
            fc2_w_addr = 4'(k);
            fc2_w_data = 8'(v);
            tick();
        end
        fc2_w_wr = 1'b0;
    endtask

    // Pulses start and waits (bounded) for done; inject_at >= 0 fires a
    // set of writes plus a second start that must all be ignored mid-run.
    task automatic run(input string tag, input int inject_at, input int exp_logit);
        int cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_done_clr"}, int'(done), 0);
        cnt = 0;
        while (!done && cnt < 2000) begin
            if (cnt == inject_at) begin
                in_wr = 1'b1;    in_addr = 8'd0;     in_data = 8'd127;
                fc1_w_wr = 1'b1; fc1_w_addr = 16'd0; fc1_w_data = 8'd127;
                fc2_w_wr = 1'b1; fc2_w_addr = 4'd0;  fc2_w_data = 8'd99;
                start = 1'b1;
            end
            tick();
            cnt++;
            in_wr = 1'b0; fc1_w_wr = 1'b0; fc2_w_wr = 1'b0; start = 1'b0;
        end
        check({tag, "_latency"}, cnt, 1331);
        check({tag, "_logit"}, int'($signed(fc2_logit)), exp_logit);
    endtask

    task automatic check_relu(input string tag, input int mul, input int add);
        for (int n = 0; n < 10; n++)
            check($sformatf("%s_relu%0d", tag, n), int'(dut.fc1_out_relu[n]), mul * (n + 1) + add);
    endtask

    initial begin
        vecs[0] = '{in_mode: 0, w1_mode: 0, w2_val: 1,   relu_mul: 58, relu_add: 0,       exp_logit: 3190};
        vecs[1] = '{in_mode: 0, w1_mode: 1, w2_val: 1,   relu_mul: 0,  relu_add: 0,       exp_logit: 0};
        vecs[2] = '{in_mode: 1, w1_mode: 2, w2_val: 127, relu_mul: 0,  relu_add: 2129028, exp_logit: 8388607};

        rst_n = 1'b0;
        in_wr = 1'b0; fc1_w_wr = 1'b0; fc2_w_wr = 1'b0; start = 1'b0;
        in_addr = '0; in_data = '0; fc1_w_addr = '0; fc1_w_data = '0;
        fc2_w_addr = '0; fc2_w_data = '0;
        tick();
        tick();
        check("rst_done", int'(done), 0);
        check("rst_logit", int'($signed(fc2_logit)), 0);
        check_relu("rst", 0, 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 3; v++) begin
            load_in(vecs[v].in_mode);
            load_w1(vecs[v].w1_mode);
            load_w2(vecs[v].w2_val);
            run($sformatf("vec%0d", v), -1, vecs[v].exp_logit);
            check($sformatf("vec%0d_done_hold", v), int'(done), 1);
            check_relu($sformatf("vec%0d", v), vecs[v].relu_mul, vecs[v].relu_add);
        end

        // Negative logit on a rerun with the basic buffers and w2 = -1.
        load_in(0);
        load_w1(0);
        load_w2(-1);
        run("neg", -1, -3190);
        check_relu("neg", 58, 0);

        // Out-of-range writes while idle, then writes and start mid-run.
        load_w2(1);
        in_wr = 1'b1;    in_addr = 8'd132;      in_data = 8'd100;
        fc1_w_wr = 1'b1; fc1_w_addr = 16'd1320; fc1_w_data = 8'h80;
        fc2_w_wr = 1'b1; fc2_w_addr = 4'd10;    fc2_w_data = 8'd50;
        tick();
        in_wr = 1'b0; fc1_w_wr = 1'b0; fc2_w_wr = 1'b0;
        run("guard", 100, 3190);
        run("guard_again", -1, 3190);

        // Async reset in the middle of FC1, then a clean run on kept buffers.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 500; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_done", int'(done), 0);
        check("midrst_logit", int'($signed(fc2_logit)), 0);
        check("midrst_relu0", int'(dut.fc1_out_relu[0]), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_idle_done", int'(done), 0);
        run("after_rst", -1, 3190);
        check_relu("after_rst", 58, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
